// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: Moore FSM with registered per-state controls plus immsrc/alucontrol decoders.
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with illegal held high until reset.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW  = 7'b0100011, OP_R   = 7'b0110011,
                           OP_I  = 7'b0010011, OP_JAL = 7'b1101111, OP_BR  = 7'b1100011,
                           OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, JAL = 4'd8, ALUWB = 4'd9,
        BRANCH = 4'd10, LUI = 4'd11, TRAP = 4'd12
    } state_t;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    state_t st, nxt;
    ctrl_t  ctl;
    logic   taken;

    // Moore outputs of a state; registered alongside the state so they change only on the edge.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.pcupdate = 1'b1; end
            DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
            MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
            MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
            EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
            JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
            ALUWB:    c.regwrite = 1'b1;
            LUI:      begin c.resultsrc = 2'b11; c.regwrite = 1'b1; end
            BRANCH:   begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECR;
                    OP_I:         nxt = EXECI;
                    OP_JAL:       nxt = JAL;
                    OP_BR:        nxt = BRANCH;
                    OP_LUI:       nxt = LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:      nxt = TRAP;
`else
                    default:      nxt = FETCH;
`endif
                endcase
            end
            MEMADR:  nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: nxt = MEMWB;
            EXECR, EXECI, JAL: nxt = ALUWB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:    nxt = TRAP;
`endif
            default: nxt = FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic ill_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= FETCH;
            ctl   <= state_ctrl(FETCH);
            ill_q <= 1'b0;
        end else begin
            st    <= nxt;
            ctl   <= state_ctrl(nxt);
            ill_q <= ill_q | (nxt == TRAP);
        end
    end
    assign illegal = ill_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= FETCH;
            ctl <= state_ctrl(FETCH);
        end else begin
            st  <= nxt;
            ctl <= state_ctrl(nxt);
        end
    end
    assign illegal = 1'b0;
`endif

    // Branch resolution uses the live zero flag from the ALU in the BRANCH cycle.
    assign taken = ctl.branch & ((funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0);

    assign pcwrite   = ~reset & (ctl.pcupdate | taken);
    assign irwrite   = ~reset & ctl.irwrite;
    assign regwrite  = ~reset & ctl.regwrite;
    assign memwrite  = ~reset & ctl.memwrite;
    assign adrsrc    = ctl.adrsrc;
    assign resultsrc = ctl.resultsrc;
    assign alusrca   = ctl.alusrca;
    assign alusrcb   = ctl.alusrcb;
    assign state     = st;

    always_comb begin
        alucontrol = 3'b000;
        case (ctl.aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    always_comb begin
        immsrc = 3'b000;
        case (op)
            OP_SW:   immsrc = 3'b001;
            OP_BR:   immsrc = 3'b010;
            OP_JAL:  immsrc = 3'b011;
            OP_LUI:  immsrc = 3'b100;
            default: immsrc = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes expected per-cycle outputs, a monitor compares.
// Define ILLEGAL_TRAP_EN for both bench and RTL to exercise the trap build.
module tb_multicycle_controller;
    logic       clk = 1'b0, reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0, zero = 1'b0;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb;
    logic [2:0] immsrc, alucontrol;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                           JL = 7'b1101111, BR = 7'b1100011, LU = 7'b0110111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu;
        logic       ill;
    } exp_t;

    exp_t expq[$];
    int   tests = 0, fails = 0;

    function automatic logic known(input logic [6:0] o);
        return o inside {LW, SW, RT, IT, JL, BR, LU};
    endfunction

    // Expected outputs of one cycle, given which step of the instruction the core is in.
    function automatic exp_t model(input int s, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input logic rst, input logic ill);
        exp_t e;
        logic [2:0] fa;
        e = '0;
        e.st = 4'(s);
        e.ill = ill;
        e.imm = (o == SW) ? 3'd1 : (o == BR) ? 3'd2 : (o == JL) ? 3'd3 : (o == LU) ? 3'd4 : 3'd0;
        case (f3)
            3'b000:  fa = (f7 && o[5]) ? 3'b001 : 3'b000;
            3'b010:  fa = 3'b101;
            3'b110:  fa = 3'b011;
            3'b111:  fa = 3'b010;
            default: fa = 3'b000;
        endcase
        case (s)
            0:  begin e.irw = 1; e.sb = 2; e.rs = 2; e.pcw = 1; end
            1:  begin e.sa = 1; e.sb = 1; end
            2:  begin e.sa = 2; e.sb = 1; end
            3:  e.adr = 1;
            4:  begin e.rs = 1; e.rw = 1; end
            5:  begin e.adr = 1; e.mw = 1; end
            6:  begin e.sa = 2; e.alu = fa; end
            7:  begin e.sa = 2; e.sb = 1; e.alu = fa; end
            8:  begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            9:  e.rw = 1;
            10: begin e.sa = 2; e.alu = 3'b001; e.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0; end
            11: begin e.rs = 3; e.rw = 1; end
            default: ;
        endcase
        if (rst) begin e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0; end
        return e;
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e, g;
            e = expq.pop_front();
            g = '{state, pcwrite, irwrite, regwrite, memwrite, adrsrc, resultsrc, alusrca, alusrcb,
                  immsrc, alucontrol, illegal};
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL cycle op=%b f3=%b exp_state=%0d: got %h expected %h", op, funct3, e.st, g, e);
            end
        end
    end

    // Entered and left at posedge+1; one instruction from FETCH to its last state.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        int seq[$];
        case (o)
            LW: seq = '{0, 1, 2, 3, 4};
            SW: seq = '{0, 1, 2, 5};
            RT: seq = '{0, 1, 6, 9};
            IT: seq = '{0, 1, 7, 9};
            JL: seq = '{0, 1, 8, 9};
            BR: seq = '{0, 1, 10};
            LU: seq = '{0, 1, 11};
            default: seq = '{0, 1};
        endcase
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        foreach (seq[i]) expq.push_back(model(seq[i], o, f3, f7, z, 1'b0, 1'b0));
        repeat (seq.size()) begin @(posedge clk); #1; end
    endtask

    task automatic run_random();
        logic [6:0] o;
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = JL; 5: o = BR; 6: o = LU;
            default: begin
`ifdef ILLEGAL_TRAP_EN
                o = RT;
`else
                do o = 7'($urandom); while (known(o));
`endif
            end
        endcase
        run(o, (o == BR) ? 3'($urandom_range(0, 3)) : 3'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        int guard;
        @(posedge clk); #1;
        expq.push_back(model(0, op, funct3, funct7b5, zero, 1'b1, 1'b0));
        @(posedge clk); #1;
        expq.push_back(model(0, op, funct3, funct7b5, zero, 1'b1, 1'b0));
        @(posedge clk); #1;
        reset = 1'b0;

        run(LW, 3'b010, 1'b0, 1'b0);
        run(SW, 3'b010, 1'b0, 1'b0);
        run(RT, 3'b000, 1'b1, 1'b0);
        run(RT, 3'b111, 1'b0, 1'b0);
        run(RT, 3'b010, 1'b0, 1'b0);
        run(RT, 3'b110, 1'b1, 1'b0);
        run(IT, 3'b000, 1'b1, 1'b0);
        run(BR, 3'b000, 1'b0, 1'b1);
        run(BR, 3'b000, 1'b0, 1'b0);
        run(BR, 3'b001, 1'b0, 1'b1);
        run(BR, 3'b001, 1'b0, 1'b0);
        run(JL, 3'b000, 1'b0, 1'b1);
        run(LU, 3'b000, 1'b0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        run(7'b1111111, 3'b000, 1'b0, 1'b0);
`endif

        // Reset landing on the MEMWRITE cycle of a store must suppress the write.
        op = SW; funct3 = 3'b010;
        expq.push_back(model(0, SW, 3'b010, 1'b0, zero, 1'b0, 1'b0));
        expq.push_back(model(1, SW, 3'b010, 1'b0, zero, 1'b0, 1'b0));
        expq.push_back(model(2, SW, 3'b010, 1'b0, zero, 1'b0, 1'b0));
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        expq.push_back(model(5, SW, 3'b010, 1'b0, zero, 1'b1, 1'b0));
        @(posedge clk); #1;
        expq.push_back(model(0, SW, 3'b010, 1'b0, zero, 1'b1, 1'b0));
        @(posedge clk); #1;
        reset = 1'b0;

        repeat (200) run_random();

`ifdef ILLEGAL_TRAP_EN
        op = 7'b1111111; funct3 = 3'b000;
        expq.push_back(model(0, op, funct3, 1'b0, zero, 1'b0, 1'b0));
        expq.push_back(model(1, op, funct3, 1'b0, zero, 1'b0, 1'b0));
        repeat (4) expq.push_back(model(12, op, funct3, 1'b0, zero, 1'b0, 1'b1));
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b1;
        expq.push_back(model(12, op, funct3, 1'b0, zero, 1'b1, 1'b1));
        @(posedge clk); #1;
        expq.push_back(model(0, op, funct3, 1'b0, zero, 1'b1, 1'b0));
        @(posedge clk); #1;
        reset = 1'b0;
        run(LU, 3'b000, 1'b0, 1'b0);
`endif

        guard = 0;
        while (expq.size() > 0 && guard < 20) begin @(posedge clk); guard++; end
        if (expq.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
